// File: rtl/rmt_pktgen_pkg.sv
// rmt_pktgen_pkg: shared types and helpers for the AXIS packet generator/monitor
package rmt_pktgen_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    localparam int MAX_KEEP = 128;

    function automatic int KEEP_W(input int dw);
        return dw / 8;
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_KEEP-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP; i++) n = n + 8'(v[i]);
        return n;
    endfunction

    function automatic logic [63:0] beat_word(input logic [31:0] seq, input logic [31:0] k);
        return {seq, k};
    endfunction

endpackage

// File: rtl/axis_stream_monitor.sv
// axis_stream_monitor: counts packets, beats and bytes seen on a snooped AXIS port
module axis_stream_monitor
    import rmt_pktgen_pkg::*;
#(
    parameter int KEEP      = 64,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [KEEP-1:0]      tkeep,
    input  logic                 tvalid,
    input  logic                 tready,
    input  logic                 tlast,
    output logic [CNT_WIDTH-1:0] rx_pkts,
    output logic [CNT_WIDTH-1:0] rx_beats,
    output logic [CNT_WIDTH-1:0] rx_bytes
);

    logic hit;
    assign hit = en && tvalid && tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rx_pkts  <= '0;
            rx_beats <= '0;
            rx_bytes <= '0;
        end else if (clr) begin
            rx_pkts  <= '0;
            rx_beats <= '0;
            rx_bytes <= '0;
        end else if (hit) begin
            rx_beats <= rx_beats + CNT_WIDTH'(1);
            rx_bytes <= rx_bytes + CNT_WIDTH'(popcount(MAX_KEEP'(tkeep)));
            rx_pkts  <= tlast ? rx_pkts + CNT_WIDTH'(1) : rx_pkts;
        end
    end

endmodule

// File: rtl/axis_pkt_gen_mon.sv
// axis_pkt_gen_mon: templated AXIS packet generator with an output-side monitor
module axis_pkt_gen_mon
    import rmt_pktgen_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int LEN_WIDTH          = 16,
    parameter int CNT_WIDTH          = 64,
    localparam int KEEP              = KEEP_W(C_AXIS_DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic                          stop,
    input  logic [LEN_WIDTH-1:0]          cfg_pkt_beats,
    input  logic [KEEP-1:0]               cfg_last_keep,
    input  logic [CNT_WIDTH-1:0]          cfg_num_pkts,
    input  logic [LEN_WIDTH-1:0]          cfg_gap,
    input  logic [C_AXIS_DATA_WIDTH-1:0]  cfg_hdr,
    input  logic [C_AXIS_TUSER_WIDTH-1:0] cfg_tuser,
    output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP-1:0]               m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    input  logic [KEEP-1:0]               mon_tkeep,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_WIDTH-1:0]          tx_pkts,
    output logic [CNT_WIDTH-1:0]          tx_bytes,
    output logic [CNT_WIDTH-1:0]          rx_pkts,
    output logic [CNT_WIDTH-1:0]          rx_beats,
    output logic [CNT_WIDTH-1:0]          rx_bytes,
    output logic [CNT_WIDTH-1:0]          run_cycles
);

    state_t                        state;
    logic [LEN_WIDTH-1:0]          beats_r, gap_r, beat_idx, gap_cnt;
    logic [KEEP-1:0]               last_keep_r;
    logic [CNT_WIDTH-1:0]          num_r;
    logic [C_AXIS_DATA_WIDTH-1:0]  hdr_r;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_r;
    logic                          stop_pend, is_last, xfer, end_run, launch;

    assign busy          = state == SEND || state == GAP;
    assign done          = state == FIN;
    assign launch        = state == IDLE && start;
    assign m_axis_tvalid = state == SEND;
    assign is_last       = beat_idx == beats_r - LEN_WIDTH'(1);
    assign xfer          = m_axis_tvalid && m_axis_tready;
    assign end_run       = (num_r != '0 && tx_pkts + CNT_WIDTH'(1) == num_r) || stop_pend || stop;
    // Outputs are gated by tvalid so everything reads zero outside a beat, including reset
    assign m_axis_tlast  = m_axis_tvalid && is_last;
    assign m_axis_tkeep  = !m_axis_tvalid ? '0 : is_last ? last_keep_r : '1;
    assign m_axis_tuser  = m_axis_tvalid ? tuser_r : '0;
    assign m_axis_tdata  = !m_axis_tvalid ? '0 :
                           beat_idx == '0 ? hdr_r :
                           C_AXIS_DATA_WIDTH'(beat_word(tx_pkts[31:0], 32'(beat_idx)));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            beats_r     <= '0;
            gap_r       <= '0;
            beat_idx    <= '0;
            gap_cnt     <= '0;
            last_keep_r <= '0;
            num_r       <= '0;
            hdr_r       <= '0;
            tuser_r     <= '0;
            stop_pend   <= 1'b0;
            tx_pkts     <= '0;
            tx_bytes    <= '0;
            run_cycles  <= '0;
        end else begin
            if (busy) run_cycles <= run_cycles + CNT_WIDTH'(1);
            if (xfer) tx_bytes <= tx_bytes + CNT_WIDTH'(popcount(MAX_KEEP'(m_axis_tkeep)));
            case (state)
                IDLE: if (start) begin
                    beats_r     <= cfg_pkt_beats == '0 ? LEN_WIDTH'(1) : cfg_pkt_beats;
                    gap_r       <= cfg_gap;
                    last_keep_r <= cfg_last_keep;
                    num_r       <= cfg_num_pkts;
                    hdr_r       <= cfg_hdr;
                    tuser_r     <= cfg_tuser;
                    beat_idx    <= '0;
                    stop_pend   <= 1'b0;
                    tx_pkts     <= '0;
                    tx_bytes    <= '0;
                    run_cycles  <= '0;
                    state       <= SEND;
                end
                SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (xfer && !is_last) beat_idx <= beat_idx + LEN_WIDTH'(1);
                    if (xfer && is_last) begin
                        beat_idx <= '0;
                        tx_pkts  <= tx_pkts + CNT_WIDTH'(1);
                        gap_cnt  <= gap_r;
                        state    <= end_run ? FIN : gap_r != '0 ? GAP : SEND;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - LEN_WIDTH'(1);
                    state   <= (stop || stop_pend) ? FIN : gap_cnt == LEN_WIDTH'(1) ? SEND : GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_stream_monitor #(
        .KEEP      (KEEP),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mon (
        .clk      (clk),
        .aresetn  (aresetn),
        .clr      (launch),
        .en       (busy || rx_pkts != tx_pkts),
        .tkeep    (mon_tkeep),
        .tvalid   (mon_tvalid),
        .tready   (mon_tready),
        .tlast    (mon_tlast),
        .rx_pkts  (rx_pkts),
        .rx_beats (rx_beats),
        .rx_bytes (rx_bytes)
    );

endmodule

// File: doc/axis_pkt_gen_mon.md
Name: axis_pkt_gen_mon

Overview:
- Synthesizable, run-time configurable AXI-Stream packet generator with an attached output monitor, for bring-up and throughput measurement of the RMT pipeline.
- Generator drives the pipeline's slave AXIS port with templated packets: configurable length, last-beat keep, packet count, inter-packet gap and back-pressure compliance.
- Monitor snoops the pipeline's master AXIS port and counts packets, beats, bytes and cycles, so results can be read over the register bus.

Parameters:
- C_AXIS_DATA_WIDTH, 512, tdata width in bits; tkeep width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width in bits.
- LEN_WIDTH, 16, width of the beats-per-packet and gap configuration fields.
- CNT_WIDTH, 64, width of every statistics counter and of the packet sequence number.

Ports:
- clk  in  1  axis clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  pulse; starts a run when idle.
- stop  in  1  pulse; ends a run at the next packet boundary.
- cfg_pkt_beats  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
- cfg_last_keep  in  KEEP  tkeep for the final beat.
- cfg_num_pkts  in  CNT_WIDTH  packets per run; 0 means run until stopped.
- cfg_gap  in  LEN_WIDTH  idle cycles between packets.
- cfg_hdr  in  C_AXIS_DATA_WIDTH  tdata for beat 0.
- cfg_tuser  in  C_AXIS_TUSER_WIDTH  tuser, driven on every beat.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per widths  generator stream.
- m_axis_tready  in  1  generator back-pressure.
- mon_tkeep  in  KEEP  snooped tkeep of the pipeline output.
- mon_tvalid, mon_tready, mon_tlast  in  1  snooped handshake of the pipeline output.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- tx_pkts, tx_bytes, rx_pkts, rx_beats, rx_bytes, run_cycles  out  CNT_WIDTH  statistics.

Behaviour:
- Reset: FSM to IDLE. All outputs 0: tvalid, tlast, busy, done, tdata, tkeep and every counter. Assertion is asynchronous, so an in-flight beat is dropped immediately.
- FSM has four states: IDLE, SEND, GAP, FIN.
- IDLE, start=1: latch all cfg_* inputs; clear tx_*, rx_* and run_cycles; go to SEND. tvalid is asserted on the cycle after start is sampled.
- IDLE: stop is ignored.
- start while busy is ignored; configuration stays frozen for the whole run.
- Beat data: beat 0 carries the latched cfg_hdr. Beat k>0 carries zero-extended {pkt_seq[31:0], k[31:0]}, where pkt_seq is the packet index starting at 0.
- tkeep is all ones except on the final beat, which uses cfg_last_keep. tlast is asserted on beat cfg_pkt_beats-1.
- Handshake: a beat transfers only when tvalid&&tready. tdata/tkeep/tlast/tuser are held stable while tvalid=1 and tready=0. tvalid never drops mid-packet.
- End of packet (tlast transfer): tx_pkts+1. tx_bytes is accumulated per transferred beat as the popcount of tkeep.
- Then:
  - cfg_num_pkts reached, or stop pending: go to FIN.
  - else, gap>0: go to GAP.
  - else: stay in SEND (back-to-back packets, no bubble).
- GAP: down-counts cfg_gap cycles with tvalid=0, then goes to SEND. A stop during GAP goes to FIN on the next cycle.
- stop during SEND is latched as pending and honoured at the tlast transfer; a packet is never truncated.
- FIN: one cycle with done=1 and busy=0, then IDLE.
- run_cycles increments every cycle while busy.
- Monitor, active while busy or until rx_pkts==tx_pkts after the run:
  - on mon_tvalid&&mon_tready: rx_beats+1, rx_bytes+=popcount(mon_tkeep);
  - rx_pkts+1 additionally on mon_tlast.
- All counters wrap modulo 2^CNT_WIDTH. tx_pkts/tx_bytes and rx_* are updated in the same cycle without interaction.

Decomposition:
- Package rmt_pktgen_pkg holds: the state enum; the KEEP_W function; a popcount function; and the beat-data formatting function.
- One sub-module, axis_stream_monitor (rx counters, clear input, enable input), instantiated once.

Test Plan:
- beats=1, keep all ones, num=4, gap=0, tready=1: 4 single-beat packets on consecutive cycles -> tx_pkts=4, tx_bytes=256, done pulses once.
- beats=3, last_keep=0x0F, num=2, gap=2: beat pattern valid×3, idle×2, valid×3 -> tx_bytes=2*(128+4)=264; beat 1 of packet 1 = {1,1}.
- Random tready throttling at 50%: payload is stable while stalled and tlast is placed correctly -> tx_pkts=num.
- num=0, stop asserted mid-packet of beats=4: the packet completes with tlast, then FIN; tx_pkts equals the packets started.
- aresetn deasserted mid-packet: tvalid=0 asynchronously; after release, a new start begins again with pkt_seq=0.
- Loopback of m_axis onto mon_*: after done, rx_pkts==tx_pkts and rx_bytes==tx_bytes.
